// File: rtl/ioram_pkg.sv
// Shared definitions for the ioram read-port scheduler.
//   IOR_AW / IOR_LW / IOR_NREQ : default address, burst-length and client-count widths
//   IOR_RD_LAT                 : ioram read latency, i.e. depth of the owner pipeline
//   rd_state_e                 : scheduler FSM states
package ioram_pkg;
  localparam int IOR_AW     = 14;
  localparam int IOR_LW     = 14;
  localparam int IOR_NREQ   = 4;
  localparam int IOR_RD_LAT = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;
endpackage

// File: rtl/ioram_rd_sched_if.sv
// Bus bundle between the read scheduler, its clients and the ioram ports.
//   req_*      : per-client burst requests (valid/ready, base, beats-1)
//   w_addr_*   : snooped ioram write address stream
//   r_addr_*   : ioram read address stream produced by the scheduler
//   r_data_*   : ioram read data framing returned one cycle after the address
//   rd_owner   : client owning the current returned data beat
//   rd_done    : one-hot pulse on the owner's last data beat
// Modports: slave = scheduler, master = clients plus ioram environment.
interface ioram_rd_sched_if
  import ioram_pkg::*;
#(
  parameter int AW   = IOR_AW,
  parameter int LW   = IOR_LW,
  parameter int NREQ = IOR_NREQ
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_base;
  logic [NREQ*LW-1:0] req_len;
  logic               w_addr_first;
  logic               w_addr_last;
  logic               w_addr_valid;
  logic [AW-1:0]      r_addr;
  logic               r_addr_first;
  logic               r_addr_last;
  logic               r_addr_valid;
  logic               r_addr_ready;
  logic               r_data_first;
  logic               r_data_last;
  logic               r_data_valid;
  logic [IDW-1:0]     rd_owner;
  logic [NREQ-1:0]    rd_done;

  modport slave (
    input  req_valid, req_base, req_len,
    input  w_addr_first, w_addr_last, w_addr_valid,
    input  r_addr_ready, r_data_first, r_data_last, r_data_valid,
    output req_ready, r_addr, r_addr_first, r_addr_last, r_addr_valid,
    output rd_owner, rd_done
  );

  modport master (
    output req_valid, req_base, req_len,
    output w_addr_first, w_addr_last, w_addr_valid,
    output r_addr_ready, r_data_first, r_data_last, r_data_valid,
    input  req_ready, r_addr, r_addr_first, r_addr_last, r_addr_valid,
    input  rd_owner, rd_done
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : highest-priority index this cycle (register kept by the parent)
//   en_i  : when low no grant is produced
//   gnt_o : one-hot grant
//   idx_o : binary index of the grant (0 when none)
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic found;
  int   cand;

  // Scan from ptr_i upward with wrap; the first requester found wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < N; off++) begin
      cand = (int'(ptr_i) + off) % N;
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IW'(cand);
      end
    end
  end
endmodule

// File: rtl/ioram_rd_sched.sv
// Read-port scheduler for the shared ioram activation buffer.
// Grants client bursts round-robin, streams the granted burst as
// first/last/valid/ready addresses, tags returned data with its owner and
// holds off new bursts while a snooped write burst is in progress.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ioram_rd_sched_if.slave (requests, write snoop, read port, owner tags)
module ioram_rd_sched
  import ioram_pkg::*;
#(
  parameter int AW   = IOR_AW,
  parameter int LW   = IOR_LW,
  parameter int NREQ = IOR_NREQ
) (
  input logic             clk,
  input logic             rst,
  ioram_rd_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  rd_state_e       state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [AW-1:0]   base_q, base_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            in_wr_q, in_wr_d;
  logic            wr_block;
  logic            arb_en;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            hs;
  logic            in_burst;
  logic [IDW-1:0]  own_q [IOR_RD_LAT];
  logic            unused_first;

  assign unused_first = bus.r_data_first;

  // Write interlock: end of write wins over start so a one-beat write never latches.
  always_comb begin
    in_wr_d = in_wr_q;
    if (bus.w_addr_valid && bus.w_addr_last)       in_wr_d = 1'b0;
    else if (bus.w_addr_valid && bus.w_addr_first) in_wr_d = 1'b1;
  end

  assign wr_block = in_wr_q || (bus.w_addr_valid && bus.w_addr_first && !bus.w_addr_last);
  assign arb_en   = (state_q == IDLE) && !wr_block && !rst;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign in_burst = (state_q == BURST);
  assign hs       = in_burst && bus.r_addr_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          base_d  = bus.req_base[gnt_idx*AW +: AW];
          len_d   = bus.req_len[gnt_idx*LW +: LW];
          owner_d = gnt_idx;
          ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (bus.r_addr_ready) begin
          if (cnt_q == len_q) state_d = IDLE;
          else                cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      in_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      in_wr_q <= in_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q  <= base_d;
    len_q   <= len_d;
    owner_q <= owner_d;
  end

  // Owner pipeline: stage 0 follows the address handshake, later stages track ioram latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IOR_RD_LAT; i++) own_q[i] <= '0;
    end else begin
      if (hs) own_q[0] <= owner_q;
      for (int i = 1; i < IOR_RD_LAT; i++) own_q[i] <= own_q[i-1];
    end
  end

  assign bus.req_ready    = gnt;
  assign bus.r_addr_valid = in_burst;
  assign bus.r_addr       = in_burst ? base_q + AW'(cnt_q) : '0;
  assign bus.r_addr_first = in_burst && (cnt_q == '0);
  assign bus.r_addr_last  = in_burst && (cnt_q == len_q);
  assign bus.rd_owner     = own_q[IOR_RD_LAT-1];
  assign bus.rd_done      = (!rst && bus.r_data_valid && bus.r_data_last)
                            ? (NREQ'(1) << own_q[IOR_RD_LAT-1]) : '0;
endmodule

// File: tb/tb_ioram_rd_sched.sv
module tb_ioram_rd_sched;
  import ioram_pkg::*;

  localparam int AW  = 14;
  localparam int LW  = 14;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ioram_rd_sched_if #(.AW(AW), .LW(LW), .NREQ(N)) bus ();

  ioram_rd_sched #(.AW(AW), .LW(LW), .NREQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ioram read side: data framing returns one cycle after each accepted address beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.r_data_valid <= 1'b0;
      bus.r_data_first <= 1'b0;
      bus.r_data_last  <= 1'b0;
    end else begin
      bus.r_data_valid <= bus.r_addr_valid && bus.r_addr_ready;
      bus.r_data_first <= bus.r_addr_first;
      bus.r_data_last  <= bus.r_addr_last;
    end
  end

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic           first;
    logic           last;
    logic [IDW-1:0] owner;
  } beat_t;

  // Reference model: list of address beats still owed, plus request bookkeeping.
  beat_t         m_q[$];
  int            m_ptr;
  bit            m_in_wr;
  bit            m_ret_v;
  bit            m_ret_last;
  int            m_ret_owner;
  bit            pend [N];
  logic [AW-1:0] rb   [N];
  logic [LW-1:0] rl   [N];
  bit            scramble;

  int            nvec, nerr, cyc;
  int            gnt_log[$];
  logic [AW-1:0] obs_addr[$];
  int            done_cnt [N];
  int            exp_done [N];
  int            last_gnt_cyc;
  int            hs_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]           = pend[i];
      bus.req_base[i*AW +: AW]   = rb[i];
      bus.req_len[i*LW +: LW]    = rl[i];
    end
  endtask

  task automatic raise(input int i, input logic [AW-1:0] b, input logic [LW-1:0] l);
    pend[i] = 1'b1;
    rb[i]   = b;
    rl[i]   = l;
    drive();
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    obs_addr.delete();
    hs_cnt = 0;
    for (int i = 0; i < N; i++) begin
      done_cnt[i] = 0;
      exp_done[i] = 0;
    end
  endtask

  function automatic bit busy();
    bit b;
    b = (m_q.size() != 0) || m_ret_v;
    for (int i = 0; i < N; i++) if (pend[i]) b = 1'b1;
    return b;
  endfunction

  function automatic int logv(input int k);
    return (k < gnt_log.size()) ? gnt_log[k] : 99;
  endfunction

  // One clock: observe/check at negedge, advance the model, then drive after the edge.
  task automatic tick();
    bit          blocked;
    int          g;
    logic [N-1:0] eg, ed;
    beat_t       f;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int i = 0; i < N; i++)
        if (bus.req_ready[i]) begin
          gnt_log.push_back(i);
          last_gnt_cyc = cyc;
        end
      if (bus.r_addr_valid && bus.r_addr_ready) begin
        obs_addr.push_back(bus.r_addr);
        hs_cnt++;
      end
      for (int i = 0; i < N; i++) if (bus.rd_done[i]) done_cnt[i]++;

      blocked = m_in_wr || (bus.w_addr_valid && bus.w_addr_first && !bus.w_addr_last);
      if (m_q.size() == 0 && !blocked)
        for (int k = 0; k < N; k++)
          if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready", bus.req_ready, eg);
      chk("r_addr_valid", bus.r_addr_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        f = m_q[0];
        chk("r_addr_beat", {bus.r_addr, bus.r_addr_first, bus.r_addr_last},
            {f.addr, f.first, f.last});
      end
      ed = '0;
      if (m_ret_v && m_ret_last) ed[m_ret_owner] = 1'b1;
      chk("rd_done", bus.rd_done, ed);
      if (bus.r_data_valid) chk("rd_owner", bus.rd_owner, m_ret_owner);
    end

    if (rst) begin
      if (m_q.size() != 0) exp_done[m_q[0].owner]--;
      if (m_ret_v && m_ret_last) exp_done[m_ret_owner]--;
      m_q.delete();
      m_ptr   = 0;
      m_in_wr = 1'b0;
      m_ret_v = 1'b0;
    end else begin
      m_ret_v = 1'b0;
      if (m_q.size() != 0 && bus.r_addr_ready) begin
        f           = m_q.pop_front();
        m_ret_v     = 1'b1;
        m_ret_last  = f.last;
        m_ret_owner = int'(f.owner);
      end
      if (bus.w_addr_valid && bus.w_addr_last)       m_in_wr = 1'b0;
      else if (bus.w_addr_valid && bus.w_addr_first) m_in_wr = 1'b1;
      if (g >= 0) begin
        for (int k = 0; k <= int'(rl[g]); k++)
          m_q.push_back('{addr: AW'(int'(rb[g]) + k), first: (k == 0),
                          last: (k == int'(rl[g])), owner: IDW'(g)});
        m_ptr = (g + 1) % N;
        pend[g] = 1'b0;
        exp_done[g]++;
        if (scramble) begin
          rb[g] = AW'($urandom);
          rl[g] = LW'($urandom);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic zero_check(input string tag);
    @(negedge clk);
    chk(tag, {bus.req_ready, bus.r_addr, bus.r_addr_first, bus.r_addr_last,
              bus.r_addr_valid, bus.rd_owner, bus.rd_done}, '0);
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    zero_check("reset_outputs");
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    chk(tag, busy(), 1'b0);
  endtask

  logic [AW-1:0] t4_exp [4];
  int            rr_exp [5];
  int            c0, n;
  bit            wact;

  initial begin
    nvec = 0; nerr = 0; cyc = 0; last_gnt_cyc = -1;
    m_ptr = 0; m_in_wr = 1'b0; m_ret_v = 1'b0; m_ret_last = 1'b0; m_ret_owner = 0;
    scramble = 1'b0; wact = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; rb[i] = '0; rl[i] = '0;
    end
    clear_logs();
    bus.w_addr_first = 1'b0; bus.w_addr_last = 1'b0; bus.w_addr_valid = 1'b0;
    bus.r_addr_ready = 1'b1;
    drive();
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single request, client 1, base 0x100, four beats
    clear_logs();
    raise(1, 14'h0100, 14'd3);
    run_idle("t1_drain", 50);
    chk("t1_grant", logv(0), 1);
    chk("t1_beats", obs_addr.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < obs_addr.size()) chk("t1_addr", obs_addr[k], 14'h0100 + k);
    chk("t1_done", done_cnt[1], 1);

    // Round robin from reset, client 0 re-raised after its first grant
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) raise(i, AW'(16 * i), 14'd0);
    n = 0;
    while (gnt_log.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    raise(0, 14'h0040, 14'd0);
    run_idle("t2_drain", 100);
    rr_exp = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) chk("t2_order", logv(k), rr_exp[k]);
    for (int i = 0; i < N; i++) chk("t2_done", done_cnt[i], exp_done[i]);

    // Write interlock: write spans c0..c0+7, request from c0+1, grant at c0+8
    clear_logs();
    c0 = cyc;
    bus.w_addr_valid = 1'b1; bus.w_addr_first = 1'b1;
    tick();
    bus.w_addr_first = 1'b0;
    raise(2, 14'h0200, 14'd1);
    repeat (6) tick();
    bus.w_addr_last = 1'b1;
    tick();
    bus.w_addr_valid = 1'b0; bus.w_addr_last = 1'b0;
    run_idle("t3_drain", 50);
    chk("t3_grant_cyc", last_gnt_cyc, c0 + 8);
    chk("t3_grant_idx", logv(0), 2);

    // Single-beat write does not block its own cycle or later ones
    clear_logs();
    c0 = cyc;
    bus.w_addr_valid = 1'b1; bus.w_addr_first = 1'b1; bus.w_addr_last = 1'b1;
    raise(3, 14'h0300, 14'd0);
    tick();
    bus.w_addr_valid = 1'b0; bus.w_addr_first = 1'b0; bus.w_addr_last = 1'b0;
    run_idle("t3s_drain", 20);
    chk("t3s_grant_cyc", last_gnt_cyc, c0);
    c0 = cyc;
    raise(0, 14'h0310, 14'd0);
    run_idle("t3s2_drain", 20);
    chk("t3s2_grant_cyc", last_gnt_cyc, c0);

    // Backpressure and address wrap
    clear_logs();
    t4_exp = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    raise(1, 14'h3FFE, 14'd3);
    n = 0;
    while (busy() && n < 60) begin
      bus.r_addr_ready = (n % 3 == 0);
      tick();
      n++;
    end
    chk("t4_drain", busy(), 1'b0);
    bus.r_addr_ready = 1'b1;
    chk("t4_handshakes", hs_cnt, 4);
    for (int k = 0; k < 4; k++)
      if (k < obs_addr.size()) chk("t4_addr", obs_addr[k], t4_exp[k]);
    chk("t4_done", done_cnt[1], 1);

    // Reset during the second beat of an eight-beat burst
    clear_logs();
    raise(1, 14'h0200, 14'd7);
    n = 0;
    while (hs_cnt < 1 && n < 20) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    zero_check("t5_outputs_zero");
    repeat (3) tick();
    chk("t5_no_done", done_cnt[1], 0);
    clear_logs();
    raise(0, 14'h0500, 14'd1);
    raise(2, 14'h0600, 14'd1);
    run_idle("t5_drain", 50);
    chk("t5_first_after_rst", logv(0), 0);
    chk("t5_second_after_rst", logv(1), 2);

    // Randomized traffic with write snoop activity and backpressure
    clear_logs();
    scramble = 1'b1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) == 0)
          raise(i, ($urandom_range(0, 3) == 0) ? AW'(14'h3FFC + $urandom_range(0, 3)) : AW'($urandom),
                LW'($urandom_range(0, 5)));
      bus.r_addr_ready = ($urandom_range(0, 3) != 0);
      if (!wact) begin
        if ($urandom_range(0, 9) == 0) begin
          bus.w_addr_valid = 1'b1;
          bus.w_addr_first = 1'b1;
          bus.w_addr_last  = ($urandom_range(0, 2) == 0);
          wact = !bus.w_addr_last;
        end else begin
          bus.w_addr_valid = 1'b0; bus.w_addr_first = 1'b0; bus.w_addr_last = 1'b0;
        end
      end else begin
        bus.w_addr_valid = ($urandom_range(0, 1) == 1);
        bus.w_addr_first = 1'b0;
        bus.w_addr_last  = bus.w_addr_valid && ($urandom_range(0, 4) == 0);
        if (bus.w_addr_last) wact = 1'b0;
      end
      tick();
    end
    if (wact) begin
      bus.w_addr_valid = 1'b1; bus.w_addr_first = 1'b0; bus.w_addr_last = 1'b1;
      tick();
      wact = 1'b0;
    end
    bus.w_addr_valid = 1'b0; bus.w_addr_first = 1'b0; bus.w_addr_last = 1'b0;
    bus.r_addr_ready = 1'b1;
    run_idle("t6_drain", 500);
    for (int i = 0; i < N; i++) chk("t6_done_count", done_cnt[i], exp_done[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
